// File: rtl/reg_bcd_converter_if.sv
// ---------------------------------------------------------------------------
// reg_bcd_converter_if
// Request/result bundle for the register-to-BCD converter.
//   start      : conversion request (master -> slave)
//   value      : two's-complement register content (master -> slave)
//   busy       : conversion in progress (slave -> master)
//   done       : one-cycle pulse when the result outputs update
//   sign       : captured value was negative
//   bcd        : magnitude as BCD, digit 0 in bits [3:0]
//   num_digits : count of significant digits, 1..DIGITS
//   over99     : magnitude does not fit in two decimal digits
// ---------------------------------------------------------------------------
interface reg_bcd_converter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic                  sign;
  logic [4*DIGITS-1:0]   bcd;
  logic [3:0]            num_digits;
  logic                  over99;

  modport master (
    output start, value,
    input  busy, done, sign, bcd, num_digits, over99
  );

  modport slave (
    input  start, value,
    output busy, done, sign, bcd, num_digits, over99
  );
endinterface

// File: rtl/reg_bcd_converter.sv
// ---------------------------------------------------------------------------
// reg_bcd_converter
// Converts a two's-complement register value into sign + BCD magnitude using
// a serial double-dabble (shift-and-add-3), one bit per clock. Latency is a
// fixed WIDTH cycles from the start-accept edge to the done edge.
// Ports:
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of reg_bcd_converter_if (start/value in,
//             busy/done/sign/bcd/num_digits/over99 out)
// ---------------------------------------------------------------------------
module reg_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  reg_bcd_converter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic               r_sign_cap;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_mag;
  logic [BCD_W-1:0]   w_scratch_adj;
  logic [BCD_W-1:0]   w_scratch_nxt;

  // Add 3 to every digit >= 5 so the following left shift carries correctly
  // into the next decimal digit.
  function automatic logic [BCD_W-1:0] f_dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // 1 + index of the most significant non-zero digit; 1 for an all-zero value.
  function automatic logic [3:0] f_num_digits(input logic [BCD_W-1:0] s);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] != 4'd0) n = 4'(i + 1);
    end
    return n;
  endfunction

  function automatic logic f_over99(input logic [BCD_W-1:0] s);
    return |s[BCD_W-1:8];
  endfunction

  // Unsigned WIDTH-bit negation: -2^(WIDTH-1) maps to 2^(WIDTH-1).
  always_comb begin
    w_mag         = bus.value[WIDTH-1] ? (-bus.value) : bus.value;
    w_scratch_adj = f_dabble_adjust(r_scratch);
    w_scratch_nxt = {w_scratch_adj[BCD_W-2:0], r_shift[WIDTH-1]};
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (r_count == CNT_W'(WIDTH - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Control, scratch and result registers. Results are only written on the
  // final shift edge, so intermediate scratch never reaches the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count        <= '0;
      r_scratch      <= '0;
      r_sign_cap     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.sign       <= 1'b0;
      bus.bcd        <= '0;
      bus.num_digits <= 4'd1;
      bus.over99     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (w_accept) begin
        r_sign_cap <= bus.value[WIDTH-1];
        r_scratch  <= '0;
        r_count    <= '0;
        bus.busy   <= 1'b1;
      end else if (r_state == SHIFT) begin
        r_scratch <= w_scratch_nxt;
        r_count   <= r_count + CNT_W'(1);
        if (w_last) begin
          bus.bcd        <= w_scratch_nxt;
          bus.sign       <= r_sign_cap;
          bus.num_digits <= f_num_digits(w_scratch_nxt);
          bus.over99     <= f_over99(w_scratch_nxt);
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
        end
      end
    end
  end

  // Binary shift register: pure data, loaded on accept, shifted out MSB first.
  always_ff @(posedge clk) begin
    if (w_accept)               r_shift <= w_mag;
    else if (r_state == SHIFT)  r_shift <= r_shift << 1;
  end

endmodule

// File: tb/tb_reg_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_reg_bcd_converter
// Directed bench for reg_bcd_converter. Accepted requests push an expected
// result (including its done cycle) to a queue; a per-cycle monitor pops it
// when done is due and checks busy, done and the held result outputs.
// ---------------------------------------------------------------------------
module tb_reg_bcd_converter;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_bcd_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus_if ();

  reg_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  typedef struct {
    int          done_edge;
    logic [39:0] bcd;
    logic        sign;
    logic [3:0]  nd;
    logic        over99;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert    = 0;
  int          n_fail      = 0;
  int          cyc         = 0;
  int          m_done_edge = -1;
  logic [39:0] m_bcd       = '0;
  logic        m_sign      = 1'b0;
  logic [3:0]  m_nd        = 4'd1;
  logic        m_over99    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result by repeated division by ten.
  function automatic exp_t model(input logic [31:0] v, input int de);
    exp_t            e;
    logic [31:0]     mag;
    longint unsigned m;
    mag = v[31] ? (32'd0 - v) : v;
    m   = longint'(mag);
    e.bcd = '0;
    e.nd  = 4'd1;
    for (int i = 0; i < 10; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
      if (e.bcd[4*i +: 4] != 4'd0) e.nd = 4'(i + 1);
    end
    e.sign      = v[31];
    e.over99    = (mag > 32'd99);
    e.done_edge = de;
    return e;
  endfunction

  // Request acceptance: a start seen while no conversion is outstanding.
  always @(posedge clk) begin
    cyc++;
    if (reset_n && bus_if.start && cyc > m_done_edge) begin
      m_done_edge = cyc + WIDTH;
      sb_q.push_back(model(bus_if.value, m_done_edge));
    end
  end

  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    exp_done = 1'b0;
    if (!reset_n) begin
      sb_q.delete();
      m_done_edge = -1;
      m_bcd       = '0;
      m_sign      = 1'b0;
      m_nd        = 4'd1;
      m_over99    = 1'b0;
    end else if (sb_q.size() > 0 && sb_q[0].done_edge == cyc) begin
      exp_done = 1'b1;
      e        = sb_q.pop_front();
      m_bcd    = e.bcd;
      m_sign   = e.sign;
      m_nd     = e.nd;
      m_over99 = e.over99;
    end
    check("busy",       64'(bus_if.busy),       64'(cyc < m_done_edge));
    check("done",       64'(bus_if.done),       64'(exp_done));
    check("bcd",        64'(bus_if.bcd),        64'(m_bcd));
    check("sign",       64'(bus_if.sign),       64'(m_sign));
    check("num_digits", 64'(bus_if.num_digits), 64'(m_nd));
    check("over99",     64'(bus_if.over99),     64'(m_over99));
  end

  task automatic pulse_start(input logic [31:0] v);
    @(posedge clk); #1;
    bus_if.value = v;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    bus_if.value = $urandom;
  endtask

  task automatic run(input logic [31:0] v);
    pulse_start(v);
    repeat (33) @(posedge clk);
    #1;
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.value = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run(32'd0);
    run(-32'sd42);
    run(32'h7FFF_FFFF);
    run(32'h8000_0000);
    run(32'd1234567890);
    run(32'd100);
    run(-32'sd1);
    for (int i = 0; i < 4; i++) run($urandom);

    // Second start three cycles after the first must be ignored.
    pulse_start(32'd99);
    repeat (2) @(posedge clk);
    #1;
    bus_if.value = 32'd100;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.start = 1'b0;
    repeat (32) @(posedge clk);
    #1;

    // Abort at count 15 of a conversion of 12345.
    pulse_start(32'd12345);
    repeat (15) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus_if.busy), 64'd0);
    check("abort_bcd",  64'(bus_if.bcd),  64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    run(32'd7);

    // Start held high: back-to-back conversions every WIDTH+1 cycles.
    @(posedge clk); #1;
    bus_if.value = 32'd5;
    bus_if.start = 1'b1;
    repeat (3 * 33 + 2) @(posedge clk);
    #1 bus_if.start = 1'b0;
    repeat (36) @(posedge clk);
    #1;

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
